// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared single-ported 16-bit RAM.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin tie-breaking with fixed priority for requester 0.
module mem_port_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] MREAD    = 2'd1;
  localparam logic [1:0] MNONE    = 2'd2;
  localparam logic [1:0] MWRITE   = 2'd3;
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          op_read;
  logic          owner;
  logic [1:0]    cnt;
  logic          window_open;
  logic          accept;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          last_gnt;
`endif

  // A pending read owns the RAM until its data returns, so only writes let the window stay open in ISSUE.
  assign window_open = !reset &&
                       ((state == IDLE) || (state == RESP) || ((state == ISSUE) && !op_read));
  assign accept      = window_open && (r0_req || r1_req);

  always_comb begin
    sel = 1'b0;
    if (r1_req && !r0_req) begin
      sel = 1'b1;
    end
`ifndef MEM_ARB_FIXED_PRIO_EN
    else if (r0_req && r1_req) begin
      sel = ~last_gnt;
    end
`endif
  end

  assign r0_gnt    = accept && !sel;
  assign r1_gnt    = accept && sel;
  assign sel_we    = sel ? r1_we    : r0_we;
  assign sel_addr  = sel ? r1_addr  : r0_addr;
  assign sel_wdata = sel ? r1_wdata : r0_wdata;

  // mem_cmd defaults to MNONE every cycle so a command is only ever valid in its ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_cmd   <= MNONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      op_read   <= 1'b0;
      owner     <= 1'b0;
      cnt       <= 2'd0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      mem_cmd   <= MNONE;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (accept) begin
        state     <= ISSUE;
        mem_cmd   <= sel_we ? MWRITE : MREAD;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        owner     <= sel;
        op_read   <= !sel_we;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_gnt  <= sel;
`endif
      end else begin
        case (state)
          ISSUE: begin
            if (op_read) begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end else begin
              state <= IDLE;
            end
          end
          WAIT: begin
            if (cnt == 2'd0) begin
              rdata     <= mem_rdata;
              r0_rvalid <= !owner;
              r1_rvalid <= owner;
              state     <= RESP;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT with RD_LAT=1 and one with RD_LAT=3 sharing the request inputs.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [8:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;

  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;

  logic        r0_gnt_3, r1_gnt_3, r0_rvalid_3, r1_rvalid_3;
  logic [15:0] rdata_3, mem_wdata_3, mem_rdata_3;
  logic [1:0]  mem_cmd_3;
  logic [8:0]  mem_addr_3;

  logic [15:0] ram [0:511];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [0:2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(9), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(9), .DW(16), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt_3), .r0_rvalid(r0_rvalid_3),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt_3), .r1_rvalid(r1_rvalid_3),
    .rdata(rdata_3), .mem_cmd(mem_cmd_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
  );

  // RAM models: read data appears RD_LAT cycles after the MREAD command cycle.
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
    ram[1]   = 16'h1111;
    ram[2]   = 16'h2222;
    ram[3]   = 16'h3333;
    ram[5]   = 16'hABCD;
    ram[255] = 16'h0FF0;
    pipe1    = 16'h0000;
    for (int i = 0; i < 3; i++) pipe3[i] = 16'h0000;
  end

  always @(posedge clk) begin
    if (mem_cmd == 2'd3) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == 2'd1) pipe1 <= ram[mem_addr];
    if (mem_cmd_3 == 2'd1) pipe3[0] <= ram[mem_addr_3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mem_rdata   = pipe1;
  assign mem_rdata_3 = pipe3[2];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h005;
    #1;
    total++; if (r0_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_gnt: got %b want 0", r0_gnt); end
    @(negedge clk);
    r0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (mem_cmd !== 2'd2) begin bad++; $display("[TB] FAIL rst_cmd: got %0d want 2", mem_cmd); end
    total++; if (mem_addr !== 9'h000) begin bad++; $display("[TB] FAIL rst_addr: got %h want 000", mem_addr); end
    total++; if (mem_wdata !== 16'h0000) begin bad++; $display("[TB] FAIL rst_wdata: got %h want 0000", mem_wdata); end
    total++; if (rdata !== 16'h0000) begin bad++; $display("[TB] FAIL rst_rdata: got %h want 0000", rdata); end
    total++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin bad++; $display("[TB] FAIL rst_rvalid: got %b want 00", {r0_rvalid, r1_rvalid}); end
  endtask

  task automatic test_read_basic();
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h005;
    #1;
    total++; if ({r0_gnt, r1_gnt} !== 2'b10) begin bad++; $display("[TB] FAIL rd_gnt: got %b want 10", {r0_gnt, r1_gnt}); end
    @(negedge clk);
    r0_req = 1'b0;
    #1;
    total++; if (mem_cmd !== 2'd1) begin bad++; $display("[TB] FAIL rd_cmd: got %0d want 1", mem_cmd); end
    total++; if (mem_addr !== 9'h005) begin bad++; $display("[TB] FAIL rd_addr: got %h want 005", mem_addr); end
    @(negedge clk); #1;
    total++; if (r0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rd_early: got %b want 0", r0_rvalid); end
    total++; if (mem_cmd !== 2'd2) begin bad++; $display("[TB] FAIL rd_none: got %0d want 2", mem_cmd); end
    @(negedge clk); #1;
    total++; if ({r0_rvalid, r1_rvalid} !== 2'b10) begin bad++; $display("[TB] FAIL rd_rvalid: got %b want 10", {r0_rvalid, r1_rvalid}); end
    total++; if (rdata !== 16'hABCD) begin bad++; $display("[TB] FAIL rd_data: got %h want abcd", rdata); end
    @(negedge clk); #1;
    total++; if (r0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rd_pulse: got %b want 0", r0_rvalid); end
    total++; if (rdata !== 16'hABCD) begin bad++; $display("[TB] FAIL rd_hold: got %h want abcd", rdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 9'h010; r1_wdata = 16'h1234;
    #1;
    total++; if ({r0_gnt, r1_gnt} !== 2'b01) begin bad++; $display("[TB] FAIL wr_gnt0: got %b want 01", {r0_gnt, r1_gnt}); end
    @(negedge clk);
    r1_addr = 9'h011; r1_wdata = 16'h5678;
    #1;
    total++; if (r1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt1: got %b want 1", r1_gnt); end
    total++; if ({mem_cmd, mem_addr, mem_wdata} !== {2'd3, 9'h010, 16'h1234}) begin bad++; $display("[TB] FAIL wr_cmd0: got %0d/%h/%h want 3/010/1234", mem_cmd, mem_addr, mem_wdata); end
    @(negedge clk);
    r1_req = 1'b0;
    #1;
    total++; if (r1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL wr_gnt2: got %b want 0", r1_gnt); end
    total++; if ({mem_cmd, mem_addr, mem_wdata} !== {2'd3, 9'h011, 16'h5678}) begin bad++; $display("[TB] FAIL wr_cmd1: got %0d/%h/%h want 3/011/5678", mem_cmd, mem_addr, mem_wdata); end
    @(negedge clk); #1;
    total++; if (mem_cmd !== 2'd2) begin bad++; $display("[TB] FAIL wr_none: got %0d want 2", mem_cmd); end
  endtask

  task automatic test_round_robin();
    logic own, prev;
    logic [1:0] exp_g, exp_v;
    logic [15:0] exp_d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h001;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 9'h002;
      end
      if (i == 9) begin r0_req = 1'b0; r1_req = 1'b0; end
      #1;
      exp_g = 2'b00;
      exp_v = 2'b00;
      exp_d = 16'h0000;
      if ((i % 3 == 0) && (i < 9)) begin
        own = FIXED ? 1'b0 : (((i / 3) % 2) == 1);
        exp_g = own ? 2'b01 : 2'b10;
      end
      if ((i % 3 == 0) && (i > 0)) begin
        prev = FIXED ? 1'b0 : ((((i / 3) - 1) % 2) == 1);
        exp_v = prev ? 2'b01 : 2'b10;
        exp_d = prev ? 16'h2222 : 16'h1111;
      end
      total++; if ({r0_gnt, r1_gnt} !== exp_g) begin bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", i, {r0_gnt, r1_gnt}, exp_g); end
      total++; if ({r0_rvalid, r1_rvalid} !== exp_v) begin bad++; $display("[TB] FAIL rr_rvalid[%0d]: got %b want %b", i, {r0_rvalid, r1_rvalid}, exp_v); end
      if (exp_v != 2'b00) begin
        total++; if (rdata !== exp_d) begin bad++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", i, rdata, exp_d); end
      end
    end
  endtask

  task automatic test_long_latency();
    do_reset();
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h0FF;
    #1;
    total++; if (r0_gnt_3 !== 1'b1) begin bad++; $display("[TB] FAIL lat_gnt: got %b want 1", r0_gnt_3); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin r0_req = 1'b0; r1_req = 1'b1; r1_we = 1'b0; r1_addr = 9'h003; end
      if (i == 6) r1_req = 1'b0;
      #1;
      if (i == 1) begin
        total++; if ({mem_cmd_3, mem_addr_3} !== {2'd1, 9'h0FF}) begin bad++; $display("[TB] FAIL lat_cmd: got %0d/%h want 1/0ff", mem_cmd_3, mem_addr_3); end
      end
      if (i >= 1 && i <= 4) begin
        total++; if ({r1_gnt_3, r0_rvalid_3} !== 2'b00) begin bad++; $display("[TB] FAIL lat_closed[%0d]: got %b want 00", i, {r1_gnt_3, r0_rvalid_3}); end
      end
      if (i == 5) begin
        total++; if ({r0_rvalid_3, r1_gnt_3} !== 2'b11) begin bad++; $display("[TB] FAIL lat_resp: got %b want 11", {r0_rvalid_3, r1_gnt_3}); end
        total++; if (rdata_3 !== 16'h0FF0) begin bad++; $display("[TB] FAIL lat_data: got %h want 0ff0", rdata_3); end
      end
      if (i == 6) begin
        total++; if ({r0_rvalid_3, mem_cmd_3, mem_addr_3} !== {1'b0, 2'd1, 9'h003}) begin bad++; $display("[TB] FAIL lat_cmd1: got %b/%0d/%h want 0/1/003", r0_rvalid_3, mem_cmd_3, mem_addr_3); end
      end
      if (i == 9) begin
        total++; if (r1_rvalid_3 !== 1'b0) begin bad++; $display("[TB] FAIL lat_early1: got %b want 0", r1_rvalid_3); end
      end
      if (i == 10) begin
        total++; if ({r1_rvalid_3, rdata_3} !== {1'b1, 16'h3333}) begin bad++; $display("[TB] FAIL lat_resp1: got %b/%h want 1/3333", r1_rvalid_3, rdata_3); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h005;
    @(negedge clk);
    r0_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (r0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rvalid: got %b want 0", r0_rvalid); end
    total++; if (mem_cmd !== 2'd2) begin bad++; $display("[TB] FAIL mid_cmd: got %0d want 2", mem_cmd); end
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h001;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 9'h002;
    #1;
    total++; if (r0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rvalid2: got %b want 0", r0_rvalid); end
    total++; if ({r0_gnt, r1_gnt} !== 2'b10) begin bad++; $display("[TB] FAIL mid_tie: got %b want 10", {r0_gnt, r1_gnt}); end
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({r0_rvalid, rdata} !== {1'b1, 16'h1111}) begin bad++; $display("[TB] FAIL mid_resp: got %b/%h want 1/1111", r0_rvalid, rdata); end
    @(negedge clk);
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 9'h020; r0_wdata = 16'hBEEF;
    #1;
    total++; if ({r0_gnt, r1_gnt} !== 2'b10) begin bad++; $display("[TB] FAIL wr_rd_gnt0: got %b want 10", {r0_gnt, r1_gnt}); end
    @(negedge clk);
    r0_req = 1'b0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 9'h005;
    #1;
    total++; if ({r0_gnt, r1_gnt} !== 2'b01) begin bad++; $display("[TB] FAIL wr_rd_gnt1: got %b want 01", {r0_gnt, r1_gnt}); end
    total++; if ({mem_cmd, mem_addr, mem_wdata} !== {2'd3, 9'h020, 16'hBEEF}) begin bad++; $display("[TB] FAIL wr_rd_cmd0: got %0d/%h/%h want 3/020/beef", mem_cmd, mem_addr, mem_wdata); end
    @(negedge clk);
    r1_req = 1'b0;
    #1;
    total++; if ({mem_cmd, mem_addr} !== {2'd1, 9'h005}) begin bad++; $display("[TB] FAIL wr_rd_cmd1: got %0d/%h want 1/005", mem_cmd, mem_addr); end
    @(negedge clk); #1;
    total++; if ({mem_cmd, r1_rvalid} !== {2'd2, 1'b0}) begin bad++; $display("[TB] FAIL wr_rd_wait: got %0d/%b want 2/0", mem_cmd, r1_rvalid); end
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h020;
    #1;
    total++; if ({r0_rvalid, r1_rvalid, rdata} !== {2'b01, 16'hABCD}) begin bad++; $display("[TB] FAIL wr_rd_resp: got %b%b/%h want 01/abcd", r0_rvalid, r1_rvalid, rdata); end
    total++; if (r0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL wr_rd_gnt2: got %b want 1", r0_gnt); end
    @(negedge clk);
    r0_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({r0_rvalid, rdata} !== {1'b1, 16'hBEEF}) begin bad++; $display("[TB] FAIL wr_rd_back: got %b/%h want 1/beef", r0_rvalid, rdata); end
  endtask

  initial begin
    reset = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_round_robin();
    test_long_latency();
    test_reset_mid_read();
    test_write_then_read();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
